// File: rtl/spi_master_ctrl.sv
// Purpose : SPI master sequencer (modes 0-3) framing one D_PACK-bit MSB-first exchange per START.
// Latency : CS_N falls on the START-accept edge; DONE pulses CLK_DIV*(2*D_PACK+2) cycles later as CS_N rises.
// Backpr. : none; START is only looked at in IDLE, so requests made while BUSY are dropped, not queued.
//
// Ports:
//   i_clk      system clock, rising edge only
//   i_rst      synchronous active-high reset
//   i_start    transfer request (honoured in IDLE only)
//   i_tx_data  word to shift out, captured when START is accepted
//   i_c_pol    SCLK idle level, captured when START is accepted
//   i_c_ph     0: sample on leading edge, 1: sample on trailing edge; captured at accept
//   i_miso     serial data from the slave
//   o_sclk     serial clock
//   o_mosi     serial data to the slave
//   o_cs_n     active-low chip select
//   o_rx_data  last complete received word
//   o_busy     high while a frame is in progress
//   o_done     one-cycle completion strobe, coincident with CS_N rising
module spi_master_ctrl #(
    parameter int D_PACK  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [D_PACK-1:0] i_tx_data,
    input  logic              i_c_pol,
    input  logic              i_c_ph,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic [D_PACK-1:0] o_rx_data,
    output logic              o_busy,
    output logic              o_done
);

    // A one-bit counter still works for CLK_DIV=1: it never leaves zero, so every cycle ticks.
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * D_PACK + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * D_PACK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;      // cycles spent in the current half-period
    logic [TOG_W-1:0]  r_tog;      // SCLK toggles already issued in this frame
    logic [D_PACK-2:0] r_tx_sh;    // bits still to be presented after the one on MOSI
    logic [D_PACK-1:0] r_rx_sh;
    logic [D_PACK-1:0] r_rx_data;
    logic              r_cpha;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_accept;
    logic              w_toggle;
    logic              w_finish;
    logic              w_lead;
    logic              w_first;
    logic              w_last;
    logic              w_sample;
    logic              w_advance;

    assign w_tick = (r_cnt == CNT_LAST);

    // Properties of the toggle about to be issued (number r_tog+1):
    // odd-numbered toggles are leading edges.
    assign w_lead  = ~r_tog[0];
    assign w_first = (r_tog == '0);
    assign w_last  = (r_tog == TOG_LAST);

    // CPHA=0: slave data is valid before the leading edge, so capture there and
    // move MOSI on the trailing edge. CPHA=1 shifts the whole scheme by one edge.
    assign w_sample  = w_toggle & (w_lead ^ r_cpha);
    assign w_advance = w_toggle & (r_cpha ? (w_lead & ~w_first) : (~w_lead & ~w_last));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_toggle    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_tick) begin
                    w_toggle = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Half-period timer: free-runs in every non-IDLE state, so SETUP,
    // each SCLK half-period and HOLD are all exactly CLK_DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // SCLK generation and toggle count
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk <= 1'b0;
            r_tog  <= '0;
            r_cpha <= 1'b0;
        end else if (w_accept) begin
            r_sclk <= i_c_pol;
            r_tog  <= '0;
            r_cpha <= i_c_ph;
        end else if (w_toggle) begin
            r_sclk <= ~r_sclk;
            r_tog  <= r_tog + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmit path: MSB goes straight onto MOSI at accept; the rest
    // waits in r_tx_sh and is presented one bit per advance.
    // MOSI is left untouched after the frame.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_sh <= '0;
            r_mosi  <= 1'b0;
        end else if (w_accept) begin
            r_tx_sh <= i_tx_data[D_PACK-2:0];
            r_mosi  <= i_tx_data[D_PACK-1];
        end else if (w_advance) begin
            r_tx_sh <= r_tx_sh << 1;
            r_mosi  <= r_tx_sh[D_PACK-2];
        end
    end

    // ------------------------------------------------------------------
    // Receive path: MSB-first shift register, cleared per frame so a
    // reset-aborted partial word can never leak into a later result.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_sh <= '0;
        end else if (w_accept) begin
            r_rx_sh <= '0;
        end else if (w_sample) begin
            r_rx_sh <= {r_rx_sh[D_PACK-2:0], i_miso};
        end
    end

    // ------------------------------------------------------------------
    // Framing and host handshake
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_cs_n <= 1'b0;
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_cs_n    <= 1'b1;
                r_busy    <= 1'b0;
                r_rx_data <= r_rx_sh;
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_cs_n    = r_cs_n;
    assign o_rx_data = r_rx_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share stimulus,
// a mode-aware slave model watches whichever instance is selected.
module tb_spi_master_ctrl;

    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      = 1'b1;
    logic         start2   = 1'b0;
    logic         start1   = 1'b0;
    logic [D-1:0] tx_data  = '0;
    logic         cpol     = 1'b0;
    logic         cpha     = 1'b0;
    logic         sel_k1   = 1'b0;
    logic         loop_en  = 1'b0;

    logic         sclk2, mosi2, cs_n2, busy2, done2, miso2;
    logic         sclk1, mosi1, cs_n1, busy1, done1, miso1;
    logic [D-1:0] rx2, rx1;

    // slave model state
    logic         s_miso  = 1'b0;
    logic         s_cpol  = 1'b0;
    logic         s_cpha  = 1'b0;
    logic [D-1:0] s_word  = '0;
    logic [D-1:0] s_out   = '0;
    logic [D-1:0] s_rx    = '0;
    logic         prev_cs = 1'b1;
    logic         prev_sc = 1'b0;

    assign miso2 = loop_en ? mosi2 : s_miso;
    assign miso1 = loop_en ? mosi1 : s_miso;

    logic         a_sclk, a_mosi, a_cs_n, a_busy, a_done;
    logic [D-1:0] a_rx;
    assign a_sclk = sel_k1 ? sclk1 : sclk2;
    assign a_mosi = sel_k1 ? mosi1 : mosi2;
    assign a_cs_n = sel_k1 ? cs_n1 : cs_n2;
    assign a_busy = sel_k1 ? busy1 : busy2;
    assign a_done = sel_k1 ? done1 : done2;
    assign a_rx   = sel_k1 ? rx1   : rx2;

    spi_master_ctrl #(.D_PACK(D), .CLK_DIV(2)) u_k2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_tx_data(tx_data),
        .i_c_pol(cpol), .i_c_ph(cpha), .i_miso(miso2),
        .o_sclk(sclk2), .o_mosi(mosi2), .o_cs_n(cs_n2), .o_rx_data(rx2),
        .o_busy(busy2), .o_done(done2)
    );

    spi_master_ctrl #(.D_PACK(D), .CLK_DIV(1)) u_k1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_tx_data(tx_data),
        .i_c_pol(cpol), .i_c_ph(cpha), .i_miso(miso1),
        .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs_n1), .o_rx_data(rx1),
        .o_busy(busy1), .o_done(done1)
    );

    // Slave: CPHA=0 presents data at CS fall and changes on trailing edges,
    // samples on leading edges; CPHA=1 changes on leading, samples on trailing.
    always @(negedge clk) begin
        if (prev_cs && !a_cs_n) begin
            s_out = s_word;
            s_rx  = '0;
            if (!s_cpha) begin
                s_miso = s_out[D-1];
                s_out  = s_out << 1;
            end
        end else if (!prev_cs && !a_cs_n && (a_sclk !== prev_sc)) begin
            if (a_sclk != s_cpol) begin
                if (s_cpha) begin
                    s_miso = s_out[D-1];
                    s_out  = s_out << 1;
                end else begin
                    s_rx = {s_rx[D-2:0], a_mosi};
                end
            end else begin
                if (s_cpha) begin
                    s_rx = {s_rx[D-2:0], a_mosi};
                end else begin
                    s_miso = s_out[D-1];
                    s_out  = s_out << 1;
                end
            end
        end
        prev_cs = a_cs_n;
        prev_sc = a_sclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         k1;
        logic         pol;
        logic         pha;
        logic         loopb;
        logic [D-1:0] tx;
        logic [D-1:0] sword;
        logic [D-1:0] exp_rx;
        logic [D-1:0] exp_srx;
        int           exp_low;
        int           half;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int   low, tog, done_n, last, min_iv, max_iv, extra_low, extra_done;
        logic seen, done_at_rise, prev_s;
        sel_k1  = v.k1;
        loop_en = v.loopb;
        s_cpol  = v.pol;
        s_cpha  = v.pha;
        s_word  = v.sword;
        tx_data = v.tx;
        cpol    = v.pol;
        cpha    = v.pha;
        @(negedge clk);
        chk({tag, "_idle"}, 32'({a_cs_n, a_busy}), 32'h2);
        if (v.k1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        chk({tag, "_accept"}, 32'({a_cs_n, a_busy, a_sclk, a_mosi}), 32'({1'b0, 1'b1, v.pol, v.tx[D-1]}));
        low = 0; tog = 0; done_n = 0; last = -1; min_iv = 1000; max_iv = 0;
        seen = 1'b0; done_at_rise = 1'b0; prev_s = a_sclk;
        for (int c = 0; c < 200; c++) begin
            if (a_done) done_n++;
            if (a_sclk !== prev_s) begin
                tog++;
                if (last >= 0) begin
                    if (c - last < min_iv) min_iv = c - last;
                    if (c - last > max_iv) max_iv = c - last;
                end
                last = c;
            end
            prev_s = a_sclk;
            if (a_cs_n) begin
                seen = 1'b1;
                done_at_rise = a_done;
                break;
            end
            low++;
            @(negedge clk);
        end
        chk({tag, "_cs_rise_seen"}, 32'(seen), 32'h1);
        chk({tag, "_cs_low_cycles"}, 32'(low), 32'(v.exp_low));
        chk({tag, "_done_at_cs_rise"}, 32'(done_at_rise), 32'h1);
        chk({tag, "_sclk_toggles"}, 32'(tog), 32'(2 * D));
        chk({tag, "_half_min"}, 32'(min_iv), 32'(v.half));
        chk({tag, "_half_max"}, 32'(max_iv), 32'(v.half));
        chk({tag, "_rx_data"}, 32'(a_rx), 32'(v.exp_rx));
        chk({tag, "_slave_rx"}, 32'(s_rx), 32'(v.exp_srx));
        chk({tag, "_end_lines"}, 32'({a_sclk, a_mosi, a_busy}), 32'({v.pol, v.tx[0], 1'b0}));
        extra_low = 0; extra_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_done) extra_done++;
            if (!a_cs_n) extra_low++;
        end
        chk({tag, "_done_pulses"}, 32'(done_n + extra_done), 32'h1);
        chk({tag, "_no_restart"}, 32'(extra_low), 32'h0);
    endtask

    initial begin
        int   done_n, low, rises;
        logic prev_cs_l, chk_gap;

        //               k1    pol   pha   loop  tx     sword  exp_rx exp_srx low half
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5, 36, 2};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 36, 2};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 8'h7E, 8'h7E, 8'h81, 18, 1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h7E, 8'h7E, 8'h81, 18, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h96, 8'h96, 8'h5A, 18, 1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h3C, 8'h3C, 36, 2};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_k2", 32'({cs_n2, sclk2, mosi2, busy2, done2, rx2}), 32'({5'b10000, 8'h00}));
        chk("reset_k1", 32'({cs_n1, sclk1, mosi1, busy1, done1, rx1}), 32'({5'b10000, 8'h00}));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // START (with new data/mode) pulsed 10 cycles into a frame is ignored.
        sel_k1 = 1'b0; loop_en = 1'b1; s_cpol = 1'b0; s_cpha = 1'b0;
        tx_data = 8'hA5; cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        done_n = 0; low = 1; rises = 0; prev_cs_l = a_cs_n;
        for (int c = 1; c < 120; c++) begin
            if (c == 10) begin
                tx_data = 8'hFF; cpol = 1'b1; cpha = 1'b1; start2 = 1'b1;
            end
            @(negedge clk);
            start2 = 1'b0;
            if (a_done) done_n++;
            if (!a_cs_n) low++;
            if (prev_cs_l && !a_cs_n) rises++;
            prev_cs_l = a_cs_n;
        end
        chk("busy_start_done_count", 32'(done_n), 32'h1);
        chk("busy_start_cs_low", 32'(low), 32'd36);
        chk("busy_start_refall", 32'(rises), 32'h0);
        chk("busy_start_rx", 32'(a_rx), 32'hA5);
        chk("busy_start_slave_rx", 32'(s_rx), 32'hA5);
        chk("busy_start_sclk_idle", 32'(a_sclk), 32'h0);

        // Back-to-back frames with START held high; TX_DATA changes mid-frame.
        tx_data = 8'h12; cpol = 1'b0; cpha = 1'b0;
        start2 = 1'b1;
        done_n = 0; chk_gap = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 5) tx_data = 8'h34;
            if (chk_gap) begin
                chk("b2b_cs_gap_one_cycle", 32'(a_cs_n), 32'h0);
                chk_gap = 1'b0;
            end
            if (a_done) begin
                done_n++;
                if (done_n == 1) begin
                    chk("b2b_rx_first", 32'(a_rx), 32'h12);
                    chk("b2b_cs_high_on_done", 32'(a_cs_n), 32'h1);
                    chk_gap = 1'b1;
                end else begin
                    chk("b2b_rx_second", 32'(a_rx), 32'h34);
                    start2 = 1'b0;
                    break;
                end
            end
        end
        start2 = 1'b0;
        chk("b2b_done_count", 32'(done_n), 32'h2);
        low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!a_cs_n || a_done) low++;
        end
        chk("b2b_stops", 32'(low), 32'h0);

        // Reset mid-frame (with START held during reset) aborts cleanly.
        sel_k1 = 1'b0; loop_en = 1'b0; s_cpol = 1'b1; s_cpha = 1'b1; s_word = 8'h3C;
        tx_data = 8'hC3; cpol = 1'b1; cpha = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1; start2 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start2 = 1'b0;
        chk("rst_mid_outputs", 32'({a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_rx}), 32'({5'b10000, 8'h00}));
        done_n = 0; low = 0;
        repeat (60) begin
            @(negedge clk);
            if (a_done) done_n++;
            if (!a_cs_n) low++;
        end
        chk("rst_mid_no_done", 32'(done_n), 32'h0);
        chk("rst_mid_stays_idle", 32'(low), 32'h0);
        run_vec(vecs[1], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
